// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encoding and address helper for the memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_W     = WORD_SIZE * LINE_WORDS;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned TIMER_W    = 16;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [LINE_W-1:0]    line_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StBusyI = 3'd1,
        StBusyD = 3'd2,
        StDoneI = 3'd3,
        StDoneD = 3'd4
    } arb_state_e;

    // Clears the word-offset bits so the memory sees a line address.
    function automatic word_t line_align(word_t a);
        return a & ~word_t'(LINE_WORDS - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache request/response and main-memory command signals of the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  i_req;
    word_t i_addr;
    logic  i_ready;
    line_t i_rdata;
    logic  d_req;
    logic  d_we;
    word_t d_addr;
    line_t d_wdata;
    logic  d_ready;
    line_t d_rdata;
    logic  mem_read;
    logic  mem_write;
    word_t mem_addr;
    line_t mem_wdata;
    line_t mem_rdata;
    logic  busy;
    cnt_t  rd_count;
    cnt_t  wr_count;

    // Environment view: both caches plus the memory model.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr,
               mem_wdata, busy, rd_count, wr_count
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr,
               mem_wdata, busy, rd_count, wr_count
    );

endinterface

// File: rtl/arb_latency_timer.sv
// Loadable down-counter that flags when the memory latency window has elapsed.
module arb_latency_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache and D-cache line transfers.
// One transaction at a time, D side wins ties, saturating access counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned COUNT_MAX   = 16'hFFFF
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    localparam cnt_t               CntMax  = cnt_t'(COUNT_MAX);
    localparam logic [TIMER_W-1:0] LoadVal = TIMER_W'(MEM_LATENCY - 1);

    arb_state_e state_q, state_d;
    word_t      addr_q, addr_d;
    logic       we_q, we_d;
    line_t      wdata_q, wdata_d;
    line_t      i_rdata_q, i_rdata_d;
    line_t      d_rdata_q, d_rdata_d;
    cnt_t       rd_count_q, rd_count_d;
    cnt_t       wr_count_q, wr_count_d;
    logic       grant_i, grant_d;
    logic       in_busy, t_zero, finish;

    arb_latency_timer #(
        .Width(TIMER_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .load_i    (grant_i | grant_d),
        .load_val_i(LoadVal),
        .en_i      (in_busy),
        .zero_o    (t_zero)
    );

    assign in_busy = (state_q == StBusyI) || (state_q == StBusyD);
    assign finish  = in_busy && t_zero;

    // From DONE only the other side may be granted, so a requester that keeps
    // req high cannot starve its peer.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.d_req) grant_d = 1'b1;
                else if (bus.i_req) grant_i = 1'b1;
            end
            StBusyI: if (t_zero) state_d = StDoneI;
            StBusyD: if (t_zero) state_d = StDoneD;
            StDoneI: if (bus.d_req) grant_d = 1'b1; else state_d = StIdle;
            StDoneD: if (bus.i_req) grant_i = 1'b1; else state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (grant_d) state_d = StBusyD;
        else if (grant_i) state_d = StBusyI;
    end

    always_comb begin
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (grant_d) begin
            addr_d  = line_align(bus.d_addr);
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
        end else if (grant_i) begin
            addr_d = line_align(bus.i_addr);
            we_d   = 1'b0;
        end
        if (finish) begin
            if (we_q) begin
                if (wr_count_q != CntMax) wr_count_d = wr_count_q + 1'b1;
            end else begin
                if (rd_count_q != CntMax) rd_count_d = rd_count_q + 1'b1;
                if (state_q == StBusyI) i_rdata_d = bus.mem_rdata;
                else d_rdata_d = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.mem_read  = in_busy && !we_q;
    assign bus.mem_write = in_busy && we_q;
    assign bus.mem_addr  = in_busy ? addr_q : '0;
    assign bus.mem_wdata = (in_busy && we_q) ? wdata_q : '0;
    assign bus.i_ready   = (state_q == StDoneI);
    assign bus.d_ready   = (state_q == StDoneD);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.rd_count  = rd_count_q;
    assign bus.wr_count  = wr_count_q;

endmodule
